// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads one imem word per cycle
// into a small in-order queue and hands the head to decode.
module fetch_ctrl #(
    parameter int             N        = 64,
    parameter int             DEPTH    = 2,
    parameter logic [N-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic [5:0]    imem_addr,
    input  logic [31:0]   imem_q,
    input  logic          redirect,
    input  logic [N-1:0]  redirect_pc,
    output logic          instr_valid,
    output logic [31:0]   instr,
    output logic [N-1:0]  instr_pc,
    input  logic          instr_ready,
    output logic          fault,
    output logic [1:0]    dbg_state
);

    localparam int           AW   = $clog2(DEPTH);
    localparam logic [AW:0]  FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, FAULT} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    fetch_pc;
    logic [AW:0]     count;
    logic [AW-1:0]   head, tail;
    logic [31:0]     q_word [DEPTH];
    logic [N-1:0]    q_pc   [DEPTH];

    logic pop, bad, push_room, push, flush;

    // Decode handshake: the head transfers on any rising edge where
    // instr_valid and instr_ready are both high; instr/instr_pc stay stable
    // while instr_valid is high and instr_ready is low.
    always_comb begin
        pop       = instr_valid && instr_ready && !redirect;
        bad       = (fetch_pc[N-1:8] != '0) || (fetch_pc[1:0] != 2'b00);
        flush     = redirect && (state != IDLE);
        push_room = (count != FULL) || (instr_valid && instr_ready);
        push      = (state == RUN) && !bad && push_room && !redirect;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (bad) state_nxt = FAULT;
                     else if (!enable) state_nxt = PAUSE;
            PAUSE:   if (enable) state_nxt = RUN;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
        // Redirect outranks everything, but cannot start fetching from IDLE.
        if (flush) state_nxt = enable ? RUN : PAUSE;
        else if (redirect) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_word[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else begin
            state <= state_nxt;
            if (redirect) fetch_pc <= redirect_pc;
            else if (push) fetch_pc <= fetch_pc + N'(4);
            if (flush) begin
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                if (push) begin
                    q_word[tail] <= imem_q;
                    q_pc[tail]   <= fetch_pc;
                    tail         <= tail + AW'(1);
                end
                if (pop) head <= head + AW'(1);
                if (push && !pop) count <= count + (AW+1)'(1);
                else if (pop && !push) count <= count - (AW+1)'(1);
            end
        end
    end

    assign imem_addr   = fetch_pc[7:2];
    assign instr_valid = (count != '0);
    assign instr       = q_word[head];
    assign instr_pc    = q_pc[head];
    assign fault       = (state == FAULT);
    assign dbg_state   = state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a cycle-by-cycle vector table plus a few
// hand-written sequences (async reset, redirect while idle, streaming).
module tb_fetch_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [5:0]   imem_addr;
    logic [31:0]  imem_q;
    logic         redirect;
    logic [63:0]  redirect_pc;
    logic         instr_valid;
    logic [31:0]  instr;
    logic [63:0]  instr_pc;
    logic         instr_ready;
    logic         fault;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];

    typedef struct {
        logic        en;
        logic        rdy;
        logic        rd;
        logic [63:0] rpc;
        logic        v;
        logic [63:0] pc;
        logic        f;
        logic [5:0]  addr;
    } vec_t;

    vec_t vecs[35];

    fetch_ctrl #(.N(64), .DEPTH(2), .RESET_PC(64'd0)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .imem_addr   (imem_addr),
        .imem_q      (imem_q),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .fault       (fault),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    // ROM model: word 0 = f8000001, each following word adds 0x100.
    function automatic logic [31:0] rom_word(input logic [5:0] a);
        return 32'hf800_0001 + {18'b0, a, 8'b0};
    endfunction

    assign imem_q = rom_word(imem_addr);

    function automatic vec_t mk(input logic en, input logic rdy, input logic rd,
                                input logic [63:0] rpc, input logic v,
                                input logic [63:0] pc, input logic f,
                                input logic [5:0] addr);
        vec_t t;
        t.en = en; t.rdy = rdy; t.rd = rd; t.rpc = rpc;
        t.v = v; t.pc = pc; t.f = f; t.addr = addr;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic rdy, input logic rd, input logic [63:0] rpc);
        enable      = en;
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // en rdy rd rpc | valid pc fault addr
        vecs[0]  = mk(1, 0, 0, 0,      0, 0,      0, 0);
        vecs[1]  = mk(1, 0, 0, 0,      1, 0,      0, 1);
        vecs[2]  = mk(1, 0, 0, 0,      1, 0,      0, 2);
        vecs[3]  = mk(1, 0, 0, 0,      1, 0,      0, 2);
        vecs[4]  = mk(1, 0, 0, 0,      1, 0,      0, 2);
        vecs[5]  = mk(1, 0, 0, 0,      1, 0,      0, 2);
        vecs[6]  = mk(1, 1, 0, 0,      1, 'h04,   0, 3);
        vecs[7]  = mk(1, 1, 0, 0,      1, 'h08,   0, 4);
        vecs[8]  = mk(1, 1, 0, 0,      1, 'h0c,   0, 5);
        vecs[9]  = mk(1, 1, 1, 'h40,   0, 0,      0, 16);
        vecs[10] = mk(1, 1, 0, 0,      1, 'h40,   0, 17);
        vecs[11] = mk(1, 1, 0, 0,      1, 'h44,   0, 18);
        vecs[12] = mk(1, 1, 1, 'h42,   0, 0,      0, 16);
        vecs[13] = mk(1, 1, 0, 0,      0, 0,      1, 16);
        vecs[14] = mk(1, 1, 0, 0,      0, 0,      1, 16);
        vecs[15] = mk(1, 1, 1, 'h10,   0, 0,      0, 4);
        vecs[16] = mk(1, 1, 0, 0,      1, 'h10,   0, 5);
        vecs[17] = mk(1, 1, 0, 0,      1, 'h14,   0, 6);
        vecs[18] = mk(1, 0, 0, 0,      1, 'h14,   0, 7);
        vecs[19] = mk(0, 0, 0, 0,      1, 'h14,   0, 7);
        vecs[20] = mk(0, 1, 0, 0,      1, 'h18,   0, 7);
        vecs[21] = mk(0, 1, 0, 0,      0, 0,      0, 7);
        vecs[22] = mk(0, 1, 0, 0,      0, 0,      0, 7);
        vecs[23] = mk(1, 1, 0, 0,      0, 0,      0, 7);
        vecs[24] = mk(1, 1, 0, 0,      1, 'h1c,   0, 8);
        vecs[25] = mk(1, 1, 1, 'hf8,   0, 0,      0, 62);
        vecs[26] = mk(1, 1, 0, 0,      1, 'hf8,   0, 63);
        vecs[27] = mk(1, 1, 0, 0,      1, 'hfc,   0, 0);
        vecs[28] = mk(1, 0, 0, 0,      1, 'hfc,   1, 0);
        vecs[29] = mk(1, 1, 0, 0,      0, 0,      1, 0);
        vecs[30] = mk(1, 1, 0, 0,      0, 0,      1, 0);
        vecs[31] = mk(0, 1, 1, 'h20,   0, 0,      0, 8);
        vecs[32] = mk(0, 1, 0, 0,      0, 0,      0, 8);
        vecs[33] = mk(1, 1, 0, 0,      0, 0,      0, 8);
        vecs[34] = mk(1, 1, 0, 0,      1, 'h20,   0, 9);

        // Clock/reset
        reset = 1'b1;
        drive(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_pc", instr_pc, 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'd0);
        reset = 1'b0;

        // Table-driven vectors: inputs held for one edge, outputs checked after it
        for (int i = 0; i < 35; i++) begin
            drive(vecs[i].en, vecs[i].rdy, vecs[i].rd, vecs[i].rpc);
            step();
            chk($sformatf("v%0d_valid", i), 64'(instr_valid), 64'(vecs[i].v));
            chk($sformatf("v%0d_fault", i), 64'(fault), 64'(vecs[i].f));
            chk($sformatf("v%0d_addr", i), 64'(imem_addr), 64'(vecs[i].addr));
            if (vecs[i].v) begin
                chk($sformatf("v%0d_pc", i), instr_pc, vecs[i].pc);
                chk($sformatf("v%0d_instr", i), 64'(instr), 64'(rom_word(vecs[i].pc[7:2])));
            end
        end

        // Asynchronous reset mid-operation, asserted between edges
        drive(1, 0, 0, 0);
        step();
        #2 reset = 1'b1;
        #1;
        chk("async_valid", 64'(instr_valid), 64'd0);
        chk("async_instr", 64'(instr), 64'd0);
        chk("async_pc", instr_pc, 64'd0);
        chk("async_fault", 64'(fault), 64'd0);
        chk("async_addr", 64'(imem_addr), 64'd0);
        drive(0, 0, 0, 0);
        step();
        reset = 1'b0;

        // Redirect in IDLE only loads the PC; nothing is fetched until enabled
        drive(0, 1, 1, 64'h80);
        step();
        chk("idle_rd_addr", 64'(imem_addr), 64'd32);
        chk("idle_rd_valid", 64'(instr_valid), 64'd0);
        drive(0, 1, 0, 0);
        step();
        chk("idle_hold_valid", 64'(instr_valid), 64'd0);
        drive(1, 1, 0, 0);
        step();
        chk("idle_run_valid", 64'(instr_valid), 64'd0);

        // Streaming with instr_ready held: one instruction per cycle, no bubbles
        for (int i = 0; i < 12; i++) exp_q.push_back(64'h80 + 64'(4 * i));
        for (int i = 0; i < 12; i++) begin
            logic [63:0] e;
            step();
            e = exp_q.pop_front();
            chk($sformatf("stream%0d_valid", i), 64'(instr_valid), 64'd1);
            chk($sformatf("stream%0d_pc", i), instr_pc, e);
            chk($sformatf("stream%0d_instr", i), 64'(instr), 64'(rom_word(e[7:2])));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer between the 64-word instruction ROM (`imem`, 6-bit word address, combinational read) and the decode stage. It owns the fetch PC, reads one word per cycle into a small in-order instruction queue, hands instructions to decode over a valid/ready handshake, and handles branch redirects, pausing, and out-of-range/misaligned fetch faults.

## Interface
- N, 64: PC width in bits.
- DEPTH, 2: instruction queue entries; power of two, at least 2.
- RESET_PC, 0: fetch PC after reset; word-aligned, below 256.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  fetch enable; 0 pauses fetching, draining continues.
- imem_addr  out  6  word address to imem, equal to fetch_pc[7:2].
- imem_q  in  32  imem read data, valid in the same cycle as imem_addr.
- redirect  in  1  taken branch: flush the queue and load redirect_pc.
- redirect_pc  in  N  new fetch PC.
- instr_valid  out  1  queue head is valid.
- instr  out  32  queue head instruction word.
- instr_pc  out  N  PC of the queue head.
- instr_ready  in  1  decode accepts the head.
- fault  out  1  fetch stopped: PC out of range or misaligned.

## Operation
- State machine: IDLE, RUN, PAUSE, FAULT.
  - IDLE: the state after reset. Nothing is fetched. enable=1 moves to RUN.
  - RUN: fetches each cycle when push is allowed. enable=0 moves to PAUSE.
  - PAUSE: nothing is fetched. enable=1 moves to RUN.
  - FAULT: nothing is fetched. Only redirect or reset leaves it.
- Fault check, evaluated in RUN before pushing: if fetch_pc[N-1:8]≠0 or fetch_pc[1:0]≠0, no push occurs and the state moves to FAULT.
- Push: in RUN with no fault, write {imem_q, fetch_pc} to the queue tail, then fetch_pc ← fetch_pc+4 (mod 2^N).
  - Push is allowed when count<DEPTH, or when count==DEPTH and a pop happens in the same cycle.
  - When push is not allowed, fetch_pc holds.
- Pop: instr_valid & instr_ready removes the head. Draining is independent of state, so the queue also drains in PAUSE and FAULT.
- Queue outputs: instr_valid = (count≠0). instr and instr_pc come straight from registered head storage, with no combinational path from imem_q.
- Redirect, in any state except IDLE:
  - count←0, fetch_pc←redirect_pc, fault←0.
  - Any push or pop in the same cycle is discarded.
  - Next state is RUN if enable=1, otherwise PAUSE.
  - The new PC is fault-checked on the next RUN cycle.
- Redirect in IDLE: loads fetch_pc only; the state stays IDLE.
- Redirect has priority over every other event in the same cycle.
- count is a log2(DEPTH)+1-bit counter. Head and tail pointers are log2(DEPTH) bits and wrap naturally.

## Timing
- Reset values:
  - state=IDLE, fetch_pc=RESET_PC, imem_addr=RESET_PC[7:2], count=0.
  - instr_valid=0, instr=0, instr_pc=0, fault=0.
  - Queue storage is cleared to 0.
- Startup: in the first edge after reset release with enable=1, IDLE moves to RUN. The next edge pushes RESET_PC. instr_valid rises after that edge, so the first instruction is visible 2 cycles after enable is sampled.
- Fetch-to-visible latency: 1 cycle.
- Steady state with instr_ready held at 1: one instruction per cycle, with no bubbles.
- Redirect: asserted in cycle t.
  - instr_valid=0 in t+1.
  - redirect_pc is fetched at edge t+1.
  - It is visible in t+2.
- Fault: fault rises the cycle after the failing check edge. It is cleared by the edge that samples redirect.
- Falling off the end of the ROM: after PC 252 (word 63) is pushed, fetch_pc=256. The next RUN edge enters FAULT, and fault=1 from that point on.
- Reset asserted mid-operation clears everything immediately. The queue contents are lost.

## Test plan
- Reset, then enable=1 and instr_ready=1: instr_pc=0,4,8,… with one per cycle from the 2nd cycle after enable. instr equals the ROM words in order (word 0 = f8000001).
- instr_ready=0 for 5 cycles while running: count saturates at DEPTH, fetch_pc holds at 8, and instr stays at PC 0. Restoring instr_ready resumes at PC 8 with no duplicate or skipped PC.
- redirect=1 with redirect_pc=0x40 while the queue is full: the next cycle has instr_valid=0. The cycle after that has instr_pc=0x40 and instr = ROM word 16.
- redirect_pc=0x42: fault=1 and nothing is pushed. A later redirect to 0x10 clears fault and resumes at word 4.
- Run from PC 248 with instr_ready=1: PCs 248 and 252 are delivered, then fault=1 and instr_valid falls once the queue drains.
- enable=0 mid-run: fetching stops within 1 cycle and the queue drains. enable=1 resumes from the held PC.
